// File: rtl/dmem_bytelane.sv
// RV32I data memory: byte-lane stores, sign/zero-extended loads, post-reset clear, fault response.
// Optional macro DMEM_MISALIGN_TRAP_EN makes misaligned halfword/word accesses fault instead of aligning down.
module dmem_bytelane #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_fault,
    output logic              init_done
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_clr_idx;
    logic [IDX_W-1:0] w_clr_idx_nxt;

    logic [31:0]      r_mem [DEPTH_WORDS];

    logic             r_resp_valid;
    logic             r_resp_fault;
    logic [31:0]      r_resp_rdata;

    logic             w_accept;
    logic [IDX_W-1:0] w_idx;
    logic [1:0]       w_lane;
    logic [31:0]      w_word;
    logic             w_f3_ok;
    logic             w_misalign;
    logic             w_fault;
    logic             w_wr_en;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata_lane;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load_data;
    logic             w_unused_addr;

    // ---------------- Control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_INIT;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        case (r_state)
            ST_INIT: begin
                w_clr_idx_nxt = r_clr_idx + IDX_W'(1);
                if (r_clr_idx == IDX_W'(DEPTH_WORDS - 1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    assign req_ready = (r_state == ST_RUN);
    assign init_done = (r_state == ST_RUN);

    // ---------------- Request decode ----------------
    assign w_accept      = req_valid && req_ready;
    assign w_idx         = req_addr[IDX_W+1:2];
    assign w_lane        = req_addr[1:0];
    assign w_word        = r_mem[w_idx];
    assign w_unused_addr = ^req_addr[ADDR_W-1:IDX_W+2];

    always_comb begin
        w_f3_ok = 1'b0;
        if (req_we) begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010: w_f3_ok = 1'b1;
                default:                w_f3_ok = 1'b0;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_f3_ok = 1'b1;
                default:                                w_f3_ok = 1'b0;
            endcase
        end
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    // funct3[1:0] gives the access size for every legal encoding, load or store.
    assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_fault = !w_f3_ok || w_misalign;
    assign w_wr_en = w_accept && req_we && !w_fault;

    always_comb begin
        w_be         = 4'b0000;
        w_wdata_lane = '0;
        case (req_funct3[1:0])
            2'b00: begin
                w_be         = 4'b0001 << w_lane;
                w_wdata_lane = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be         = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata_lane = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                w_be         = 4'b1111;
                w_wdata_lane = req_wdata;
            end
            default: begin
                w_be         = 4'b0000;
                w_wdata_lane = '0;
            end
        endcase
    end

    // ---------------- Load extraction ----------------
    always_comb begin
        w_byte = w_word[7:0];
        case (w_lane)
            2'd0: w_byte = w_word[7:0];
            2'd1: w_byte = w_word[15:8];
            2'd2: w_byte = w_word[23:16];
            2'd3: w_byte = w_word[31:24];
            default: w_byte = w_word[7:0];
        endcase
    end

    assign w_half = req_addr[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_load_data = '0;
        case (req_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b010:  w_load_data = w_word;
            3'b100:  w_load_data = {24'h0, w_byte};
            3'b101:  w_load_data = {16'h0, w_half};
            default: w_load_data = '0;
        endcase
    end

    // ---------------- Storage ----------------
    // NOTE: the array has no reset branch; the INIT sequence clears it, which keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (r_state == ST_INIT) begin
            r_mem[r_clr_idx] <= '0;
        end else if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_lane[8*b +: 8];
                end
            end
        end
    end

    // ---------------- Registered response ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_resp_valid <= w_accept;
            r_resp_fault <= w_accept && w_fault;
            r_resp_rdata <= (w_accept && !req_we && !w_fault) ? w_load_data : '0;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_fault = r_resp_fault;
    assign resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_dmem_bytelane.sv
// Directed self-checking bench for dmem_bytelane with DEPTH_WORDS=8.
module tb_dmem_bytelane;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        init_done;

    int total = 0;
    int bad   = 0;

    logic        got_valid;
    logic        got_fault;
    logic [31:0] got_rdata;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    dmem_bytelane #(
        .ADDR_W      (32),
        .DEPTH_WORDS (DEPTH)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_fault (resp_fault),
        .init_done  (init_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a falling edge; one accepted request, response captured at the next falling edge.
    task automatic xfer(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid  = 1'b0;
        got_valid  = resp_valid;
        got_fault  = resp_fault;
        got_rdata  = resp_rdata;
    endtask

    // Holds a load request through INIT and counts cycles until ready rises.
    task automatic wait_init(output int cycles, output logic saw_resp);
        cycles     = 0;
        saw_resp   = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0;
        req_valid  = 1'b1;
        while (!req_ready && cycles < 20) begin
            @(posedge clk);
            @(negedge clk);
            cycles++;
            if (resp_valid) saw_resp = 1'b1;
        end
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        int   cyc;
        logic saw;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({req_ready, resp_valid, resp_fault, init_done, resp_rdata} !== 36'h0) begin
            bad++;
            $display("FAIL reset_outputs got ready=%b valid=%b fault=%b done=%b rdata=%h exp all 0",
                     req_ready, resp_valid, resp_fault, init_done, resp_rdata);
        end
        rst_n = 1'b1;
        wait_init(cyc, saw);
        total++;
        if (cyc != DEPTH) begin
            bad++;
            $display("FAIL init_cycles got=%0d exp=%0d", cyc, DEPTH);
        end
        total++;
        if (saw !== 1'b0) begin
            bad++;
            $display("FAIL init_ignores_req got resp_seen=%b exp=0", saw);
        end
        total++;
        if ({init_done, req_ready} !== 2'b11) begin
            bad++;
            $display("FAIL init_done got done=%b ready=%b exp 1 1", init_done, req_ready);
        end
        xfer(1'b0, 3'b010, 32'h1C, 32'h0);
        total++;
        if ({got_valid, got_fault, got_rdata} !== {2'b10, 32'h0}) begin
            bad++;
            $display("FAIL lw_cleared_1c got v=%b f=%b d=%h exp v=1 f=0 d=00000000", got_valid, got_fault, got_rdata);
        end
        xfer(1'b0, 3'b010, 32'h0, 32'h0);
        total++;
        if ({got_valid, got_fault, got_rdata} !== {2'b10, 32'h0}) begin
            bad++;
            $display("FAIL lw_cleared_0 got v=%b f=%b d=%h exp v=1 f=0 d=00000000", got_valid, got_fault, got_rdata);
        end
    endtask

    task automatic test_byte_lanes;
        logic [31:0] exp_d [3];
        logic [2:0]  f3s   [3];
        logic [31:0] adrs  [3];
        xfer(1'b1, 3'b010, 32'h4, 32'h11223344);
        xfer(1'b1, 3'b000, 32'h6, 32'hFFFFFFAA);
        total++;
        if ({got_valid, got_fault, got_rdata} !== {2'b10, 32'h0}) begin
            bad++;
            $display("FAIL sb_resp got v=%b f=%b d=%h exp v=1 f=0 d=00000000", got_valid, got_fault, got_rdata);
        end
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL resp_one_cycle got=%b exp=0", resp_valid);
        end
        f3s[0] = 3'b010; adrs[0] = 32'h4; exp_d[0] = 32'h11AA3344;
        f3s[1] = 3'b000; adrs[1] = 32'h6; exp_d[1] = 32'hFFFFFFAA;
        f3s[2] = 3'b100; adrs[2] = 32'h6; exp_d[2] = 32'h000000AA;
        for (int i = 0; i < 3; i++) begin
            xfer(1'b0, f3s[i], adrs[i], 32'h0);
            total++;
            if ({got_valid, got_fault, got_rdata} !== {2'b10, exp_d[i]}) begin
                bad++;
                $display("FAIL byte_load_%0d got v=%b f=%b d=%h exp d=%h", i, got_valid, got_fault, got_rdata, exp_d[i]);
            end
        end
    endtask

    task automatic test_halfword;
        logic [31:0] exp_d [4];
        logic [2:0]  f3s   [4];
        logic [31:0] adrs  [4];
        xfer(1'b1, 3'b010, 32'h8, 32'h12345555);
        xfer(1'b1, 3'b001, 32'hA, 32'h00008001);
        f3s[0] = 3'b001; adrs[0] = 32'hA; exp_d[0] = 32'hFFFF8001;
        f3s[1] = 3'b101; adrs[1] = 32'hA; exp_d[1] = 32'h00008001;
        f3s[2] = 3'b010; adrs[2] = 32'h8; exp_d[2] = 32'h80015555;
        f3s[3] = 3'b001; adrs[3] = 32'h8; exp_d[3] = 32'h00005555;
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, f3s[i], adrs[i], 32'h0);
            total++;
            if ({got_valid, got_fault, got_rdata} !== {2'b10, exp_d[i]}) begin
                bad++;
                $display("FAIL half_load_%0d got v=%b f=%b d=%h exp d=%h", i, got_valid, got_fault, got_rdata, exp_d[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0; req_wdata = 32'hDEADBEEF;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'h20; req_wdata = 32'h0;
        total++;
        if ({resp_valid, resp_fault, resp_rdata} !== {2'b10, 32'h0}) begin
            bad++;
            $display("FAIL b2b_first got v=%b f=%b d=%h exp v=1 f=0 d=00000000", resp_valid, resp_fault, resp_rdata);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        total++;
        if ({resp_valid, resp_fault, resp_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL b2b_wrap_load got v=%b f=%b d=%h exp v=1 f=0 d=deadbeef", resp_valid, resp_fault, resp_rdata);
        end
        xfer(1'b0, 3'b010, 32'hFFFFFFE0, 32'h0);
        total++;
        if ({got_valid, got_fault, got_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL wrap_high_addr got v=%b f=%b d=%h exp d=deadbeef", got_valid, got_fault, got_rdata);
        end
    endtask

    task automatic test_illegal;
        logic       wes [5];
        logic [2:0] f3s [5];
        wes[0] = 1'b1; f3s[0] = 3'b100;
        wes[1] = 1'b1; f3s[1] = 3'b011;
        wes[2] = 1'b1; f3s[2] = 3'b111;
        wes[3] = 1'b0; f3s[3] = 3'b011;
        wes[4] = 1'b0; f3s[4] = 3'b110;
        for (int i = 0; i < 5; i++) begin
            xfer(wes[i], f3s[i], 32'h0, 32'h00000000);
            total++;
            if ({got_valid, got_fault, got_rdata} !== {2'b11, 32'h0}) begin
                bad++;
                $display("FAIL illegal_%0d got v=%b f=%b d=%h exp v=1 f=1 d=00000000", i, got_valid, got_fault, got_rdata);
            end
        end
        xfer(1'b0, 3'b111, 32'h0, 32'h0);
        total++;
        if ({got_valid, got_fault, got_rdata} !== {2'b11, 32'h0}) begin
            bad++;
            $display("FAIL illegal_ld111 got v=%b f=%b d=%h exp v=1 f=1 d=00000000", got_valid, got_fault, got_rdata);
        end
        xfer(1'b0, 3'b010, 32'h0, 32'h0);
        total++;
        if ({got_valid, got_fault, got_rdata} !== {2'b10, 32'hDEADBEEF}) begin
            bad++;
            $display("FAIL illegal_no_write got v=%b f=%b d=%h exp d=deadbeef", got_valid, got_fault, got_rdata);
        end
    endtask

    task automatic test_misalign;
        logic [31:0] exp_lw;
        logic [31:0] exp_lh;
        logic [31:0] exp_after;
        exp_lw    = TRAP ? 32'h0 : 32'hDEADBEEF;
        exp_lh    = TRAP ? 32'h0 : 32'hFFFFBEEF;
        exp_after = TRAP ? 32'hDEADBEEF : 32'h1234BEEF;
        xfer(1'b0, 3'b010, 32'h2, 32'h0);
        total++;
        if ({got_valid, got_fault, got_rdata} !== {1'b1, TRAP, exp_lw}) begin
            bad++;
            $display("FAIL misalign_lw got v=%b f=%b d=%h exp f=%b d=%h", got_valid, got_fault, got_rdata, TRAP, exp_lw);
        end
        xfer(1'b0, 3'b001, 32'h1, 32'h0);
        total++;
        if ({got_valid, got_fault, got_rdata} !== {1'b1, TRAP, exp_lh}) begin
            bad++;
            $display("FAIL misalign_lh got v=%b f=%b d=%h exp f=%b d=%h", got_valid, got_fault, got_rdata, TRAP, exp_lh);
        end
        xfer(1'b1, 3'b001, 32'h3, 32'h00001234);
        total++;
        if ({got_valid, got_fault, got_rdata} !== {1'b1, TRAP, 32'h0}) begin
            bad++;
            $display("FAIL misalign_sh got v=%b f=%b d=%h exp f=%b d=00000000", got_valid, got_fault, got_rdata, TRAP);
        end
        xfer(1'b0, 3'b010, 32'h0, 32'h0);
        total++;
        if ({got_valid, got_fault, got_rdata} !== {2'b10, exp_after}) begin
            bad++;
            $display("FAIL misalign_after got v=%b f=%b d=%h exp d=%h", got_valid, got_fault, got_rdata, exp_after);
        end
    endtask

    task automatic test_reset_mid;
        int   cyc;
        logic saw;
        xfer(1'b1, 3'b010, 32'h4, 32'h12345678);
        req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h4;
        req_valid = 1'b1;
        @(posedge clk);
        #2;
        total++;
        if ({resp_valid, resp_rdata} !== {1'b1, 32'h12345678}) begin
            bad++;
            $display("FAIL mid_pending got v=%b d=%h exp v=1 d=12345678", resp_valid, resp_rdata);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({resp_valid, resp_fault, req_ready, init_done, resp_rdata} !== 36'h0) begin
            bad++;
            $display("FAIL mid_async_clear got v=%b f=%b ready=%b done=%b d=%h exp all 0",
                     resp_valid, resp_fault, req_ready, init_done, resp_rdata);
        end
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init(cyc, saw);
        total++;
        if (cyc != DEPTH || saw !== 1'b0) begin
            bad++;
            $display("FAIL mid_reinit got cycles=%0d resp_seen=%b exp cycles=%0d resp_seen=0", cyc, saw, DEPTH);
        end
        xfer(1'b0, 3'b010, 32'h4, 32'h0);
        total++;
        if ({got_valid, got_fault, got_rdata} !== {2'b10, 32'h0}) begin
            bad++;
            $display("FAIL mid_cleared_4 got v=%b f=%b d=%h exp d=00000000", got_valid, got_fault, got_rdata);
        end
        xfer(1'b0, 3'b010, 32'h8, 32'h0);
        total++;
        if ({got_valid, got_fault, got_rdata} !== {2'b10, 32'h0}) begin
            bad++;
            $display("FAIL mid_cleared_8 got v=%b f=%b d=%h exp d=00000000", got_valid, got_fault, got_rdata);
        end
    endtask

    initial begin
        rst_n      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        #2 rst_n   = 1'b0;
        test_reset();
        test_byte_lanes();
        test_halfword();
        test_back_to_back();
        test_illegal();
        test_misalign();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
